// File: rtl/sel_debounce_tracker.sv
// Synchronises, debounces and tracks a raw 1-bit select for the downstream decoder.
// Optional STICKY_GLITCH_EN adds a sticky flag for aborted settle windows.
module sel_debounce_tracker #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HIST_W          = 2,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_raw,
  output logic              sel_stable,
  output logic [HIST_W-1:0] sel_hist,
  output logic              sel_chg,
  output logic [CNT_W-1:0]  chg_count,
  output logic              busy
`ifdef STICKY_GLITCH_EN
  ,
  input  logic              glitch_clr,
  output logic              glitch_seen
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q;
  logic [HIST_W-1:0]      hist_q, hist_shift;
  logic                   chg_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   commit;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Sample the raw select into a plain shift chain; only the last stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], sel_raw};
  end

  // The only value that can differ from the committed one is its complement,
  // so a matching sample in SETTLE is always an abort, never a re-target.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != stable_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = ST_SETTLE;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (s == stable_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  generate
    if (HIST_W == 1) begin : g_hist1
      assign hist_shift = s;
    end else begin : g_histn
      assign hist_shift = {hist_q[HIST_W-2:0], s};
    end
  endgenerate

  assign count_d = (&count_q) ? count_q : count_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      hist_q   <= '0;
      chg_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chg_q   <= commit;
      if (commit) begin
        stable_q <= s;
        hist_q   <= hist_shift;
        count_q  <= count_d;
      end
    end
  end

  assign sel_stable = stable_q;
  assign sel_hist   = hist_q;
  assign sel_chg    = chg_q;
  assign chg_count  = count_q;
  assign busy       = (state_q == ST_SETTLE);

`ifdef STICKY_GLITCH_EN
  logic glitch_q;
  logic abort;

  assign abort = (state_q == ST_SETTLE) && (s == stable_q);

  // An abort on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             glitch_q <= 1'b0;
    else if (abort)      glitch_q <= 1'b1;
    else if (glitch_clr) glitch_q <= 1'b0;
  end

  assign glitch_seen = glitch_q;
`endif

endmodule

// File: tb/tb_sel_debounce_tracker.sv
// Bench for sel_debounce_tracker: two configurations driven from one random select
// stream, each checked cycle by cycle against a run-length reference model.
module tb_sel_debounce_tracker;

  localparam int W = 14;

  logic clk;
  logic rst;
  logic sel_raw;
  logic glitch_clr;

  logic       stab0, chg0, busy0;
  logic [1:0] hist0;
  logic [7:0] cnt0;
  logic       stab1, chg1, busy1;
  logic [0:0] hist1;
  logic [1:0] cnt1;
  logic       g0, g1;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sel_debounce_tracker #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HIST_W(2), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .rst(rst), .sel_raw(sel_raw),
    .sel_stable(stab0), .sel_hist(hist0), .sel_chg(chg0),
    .chg_count(cnt0), .busy(busy0)
`ifdef STICKY_GLITCH_EN
    , .glitch_clr(glitch_clr), .glitch_seen(g0)
`endif
  );

  sel_debounce_tracker #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .HIST_W(1), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .rst(rst), .sel_raw(sel_raw),
    .sel_stable(stab1), .sel_hist(hist1), .sel_chg(chg1),
    .chg_count(cnt1), .busy(busy1)
`ifdef STICKY_GLITCH_EN
    , .glitch_clr(glitch_clr), .glitch_seen(g1)
`endif
  );

`ifndef STICKY_GLITCH_EN
  assign g0 = 1'b0;
  assign g1 = 1'b0;
`endif

  function automatic logic [W-1:0] act0();
    return {g0, busy0, chg0, cnt0, hist0, stab0};
  endfunction

  function automatic logic [W-1:0] act1();
    return {g1, busy1, chg1, 6'b0, cnt1, 1'b0, hist1, stab1};
  endfunction

  // ---------------- reference model ----------------
  // A commit happens once the synchronised select has differed from the
  // committed value for DB consecutive samples; a matching sample mid-run aborts.
  int m_db   [2] = '{4, 1};
  int m_hmod [2] = '{4, 2};
  int m_cmax [2] = '{255, 3};
  bit m_sh   [2][2];
  bit m_stable [2];
  int m_hist [2];
  int m_count[2];
  int m_run  [2];
  bit m_chg  [2];
  bit m_glitch [2];

  function automatic logic [W-1:0] model_pack(int i);
    logic [7:0] c;
    logic [1:0] h;
    c = 8'(m_count[i]);
    h = 2'(m_hist[i]);
    return {m_glitch[i], (m_run[i] > 0), m_chg[i], c, h, m_stable[i]};
  endfunction

  task automatic model_step(int i);
    bit s;
    bit ab;
    if (rst) begin
      m_sh[i][0] = 0; m_sh[i][1] = 0;
      m_stable[i] = 0; m_hist[i] = 0; m_count[i] = 0;
      m_run[i] = 0; m_chg[i] = 0; m_glitch[i] = 0;
      return;
    end
    s  = m_sh[i][1];
    m_sh[i][1] = m_sh[i][0];
    m_sh[i][0] = sel_raw;
    m_chg[i] = 0;
    ab = 0;
    if (s != m_stable[i]) begin
      m_run[i]++;
      if (m_run[i] == m_db[i]) begin
        m_run[i]    = 0;
        m_stable[i] = s;
        m_hist[i]   = (m_hist[i] * 2 + int'(s)) % m_hmod[i];
        if (m_count[i] < m_cmax[i]) m_count[i]++;
        m_chg[i] = 1;
      end
    end else begin
      if (m_run[i] > 0) ab = 1;
      m_run[i] = 0;
    end
`ifdef STICKY_GLITCH_EN
    if (ab) m_glitch[i] = 1;
    else if (glitch_clr) m_glitch[i] = 0;
`endif
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_step(i);
    exp_q0.push_back(model_pack(0));
    exp_q1.push_back(model_pack(1));
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      n_checks++;
      if (act0() !== e) begin
        n_fail++;
        $display("FAIL cfg0_outputs t=%0t got=%h exp=%h", $time, act0(), e);
      end
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      n_checks++;
      if (act1() !== e) begin
        n_fail++;
        $display("FAIL cfg1_outputs t=%0t got=%h exp=%h", $time, act1(), e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_reset_cfg0", act0(), '0);
    check("async_reset_cfg1", act1(), '0);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic hold_level(bit lvl, int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      #1;
      sel_raw    = lvl;
      glitch_clr = ($urandom_range(0, 7) == 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int first0;
    int first1;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    sel_raw    = 1'b0;
    glitch_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    // Latency: a held 0->1 change commits on edge 6 (DB=4) and edge 3 (DB=1).
    #1 sel_raw = 1'b1;
    first0 = 0;
    first1 = 0;
    n = 0;
    while (n < 12) begin
      @(posedge clk);
      n++;
      #1;
      if (stab0 && first0 == 0) first0 = n;
      if (stab1 && first1 == 0) first1 = n;
    end
    check("latency_cfg0", W'(first0), W'(6));
    check("latency_cfg1", W'(first1), W'(3));

    // Reset while the DB=4 instance is mid-settle.
    @(negedge clk);
    #1 sel_raw = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("busy_before_reset", W'(busy0), W'(1));
    pulse_reset();

    // Glitch then explicit clear.
    hold_level(1'b1, 2);
    hold_level(1'b0, 8);
    @(negedge clk);
    #1 glitch_clr = 1'b1;
    @(negedge clk);
    #1 glitch_clr = 1'b0;

    // Toggle-and-hold, then random bursts of varying length.
    hold_level(1'b1, 10);
    hold_level(1'b0, 10);
    hold_level(1'b1, 10);
    for (int seg = 0; seg < 250; seg++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      hold_level(~sel_raw, $urandom_range(1, 12));
    end

    repeat (3) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
